xmpl_stone_drv: RTL and testbench

- Initiator for the xmpl_stone interface.
- Accepts commands (12-bit address, 32-bit data) from the processor side through a valid/ready port and buffers them in a small FIFO.
- Issues each command to xmpl_stone as a one-cycle strobe on a, with b and c driven.
- Samples xmpl_stone's 32-bit status a fixed latency later and returns it upstream through a valid/ready response port.
- Sits between the processor control logic and xmpl_stone.

---
 rtl/xmpl_stone_drv.sv | 161 ++++++++++++++++
 tb/tb_xmpl_stone_drv.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmpl_stone_drv.sv
// ============================================================================
// Module   : xmpl_stone_drv
// Summary  : xmpl_stone initiator. Buffers commands in a FIFO, strobes one
//            command at a time, returns sampled status on a response port.
//            Optional issued-command counter: define XMPL_STONE_DRV_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xmpl_stone_drv #(
  parameter int CMD_DEPTH = 4,
  parameter int RESP_LAT  = 2
`ifdef XMPL_STONE_DRV_CNT_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [11:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        xmpl_stone_a_o,
  output logic [11:0] xmpl_stone_b_o,
  output logic [31:0] xmpl_stone_c_o,
  input  logic [31:0] xmpl_stone_status_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_status_o,
  output logic        busy_o
`ifdef XMPL_STONE_DRV_CNT_EN
  , output logic [CNT_W-1:0] cmd_count_o
`endif
);

  localparam int c_ptr_w = $clog2(CMD_DEPTH) + 1;
  localparam int c_lw    = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [c_lw-1:0] c_lat_m1 = c_lw'(RESP_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [43:0]          r_mem [CMD_DEPTH];
  logic [c_lw-1:0]      r_cnt, w_cnt_nxt;
  logic                 r_a, r_rsp_valid, w_rsp_valid_nxt;
  logic [11:0]          r_b;
  logic [31:0]          r_c, r_rsp_status;
  logic                 w_full, w_empty, w_push, w_pop, w_capture;

  // Extra MSB on each pointer distinguishes full from empty at equal index.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                   (r_wr_ptr[c_ptr_w-2:0] == r_rd_ptr[c_ptr_w-2:0]);
  assign w_push  = cmd_valid_i && !w_full;

  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_capture       = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = c_lat_m1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture       = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ptr_w-2:0]] <= {cmd_addr_i, cmd_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_a          <= 1'b0;
      r_b          <= '0;
      r_c          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        {r_b, r_c} <= r_mem[r_rd_ptr[c_ptr_w-2:0]];
      end
      // A pop always leads into the single ISSUE cycle, so the strobe tracks it.
      r_a         <= w_pop;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_capture) r_rsp_status <= xmpl_stone_status_i;
    end
  end

`ifdef XMPL_STONE_DRV_CNT_EN
  logic [CNT_W-1:0] r_cmd_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cmd_count <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cmd_count <= r_cmd_count + 1'b1;
    end
  end

  assign cmd_count_o = r_cmd_count;
`endif

  assign cmd_ready_o    = !w_full;
  assign xmpl_stone_a_o = r_a;
  assign xmpl_stone_b_o = r_b;
  assign xmpl_stone_c_o = r_c;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_status_o   = r_rsp_status;
  assign busy_o         = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_xmpl_stone_drv.sv
// ============================================================================
// Module   : tb_xmpl_stone_drv
// Summary  : Directed self-checking bench for xmpl_stone_drv (RESP_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xmpl_stone_drv;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [11:0] cmd_addr_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic        xmpl_stone_a_o;
  logic [11:0] xmpl_stone_b_o;
  logic [31:0] xmpl_stone_c_o;
  logic [31:0] xmpl_stone_status_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_status_o;
  logic        busy_o;
`ifdef XMPL_STONE_DRV_CNT_EN
  logic [3:0]  cmd_count_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [11:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  xmpl_stone_drv #(
    .CMD_DEPTH(4),
    .RESP_LAT (2)
`ifdef XMPL_STONE_DRV_CNT_EN
    , .CNT_W  (4)
`endif
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .cmd_valid_i        (cmd_valid_i),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_addr_i         (cmd_addr_i),
    .cmd_data_i         (cmd_data_i),
    .xmpl_stone_a_o     (xmpl_stone_a_o),
    .xmpl_stone_b_o     (xmpl_stone_b_o),
    .xmpl_stone_c_o     (xmpl_stone_c_o),
    .xmpl_stone_status_i(xmpl_stone_status_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_status_o       (rsp_status_o),
    .busy_o             (busy_o)
`ifdef XMPL_STONE_DRV_CNT_EN
    , .cmd_count_o      (cmd_count_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: one entry per cycle with the strobe high.
  always @(negedge clk) begin
    if (xmpl_stone_a_o === 1'b1) begin
      log_addr.push_back(xmpl_stone_b_o);
      log_data.push_back(xmpl_stone_c_o);
      log_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (xmpl_stone_a_o !== 1'b0) begin miscompares++; $display("FAIL reset_a got %b want 0", xmpl_stone_a_o); end
    vectors++;
    if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
    vectors++;
    if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_o); end
    vectors++;
    if ({xmpl_stone_b_o, xmpl_stone_c_o, rsp_status_o} !== 76'd0) begin
      miscompares++;
      $display("FAIL reset_data got b=%h c=%h s=%h want zeros", xmpl_stone_b_o, xmpl_stone_c_o, rsp_status_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cmd_valid_i = (k == 0);
      cmd_addr_i  = 12'h0A5;
      cmd_data_i  = 32'hDEADBEEF;
      xmpl_stone_status_i = (k == 4) ? 32'h12345678 : (32'hBAD00000 + 32'(k));
      rsp_ready_i = (k == 5);
      vectors++;
      if (xmpl_stone_a_o !== (k == 2)) begin miscompares++; $display("FAIL single_strobe k=%0d got %b want %b", k, xmpl_stone_a_o, (k == 2)); end
      if (k == 2) begin
        vectors++;
        if (xmpl_stone_b_o !== 12'h0A5 || xmpl_stone_c_o !== 32'hDEADBEEF) begin
          miscompares++;
          $display("FAIL single_bc got %h/%h want 0a5/deadbeef", xmpl_stone_b_o, xmpl_stone_c_o);
        end
      end
      vectors++;
      if (rsp_valid_o !== (k == 5)) begin miscompares++; $display("FAIL single_rsp_valid k=%0d got %b want %b", k, rsp_valid_o, (k == 5)); end
      if (k == 5 || k == 6) begin
        vectors++;
        if (rsp_status_o !== 32'h12345678) begin miscompares++; $display("FAIL single_status k=%0d got %h want 12345678", k, rsp_status_o); end
      end
      if (k >= 7) begin
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy k=%0d got %b want 0", k, busy_o); end
      end
      step();
    end
  endtask

  task automatic test_fill();
    int accepted = 0;
    int waited = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cmd_valid_i = 1'b1;
      cmd_addr_i  = 12'h100 + 12'(i);
      cmd_data_i  = 32'hC0DE0000 + 32'(i);
      if (cmd_ready_o) accepted++;
      if (i == 5) begin
        vectors++;
        if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_ready_6th got %b want 0", cmd_ready_o); end
      end
      step();
    end
    cmd_valid_i = 1'b0;
    vectors++;
    if (accepted != 5) begin miscompares++; $display("FAIL fill_accepted got %0d want 5", accepted); end
    repeat (3) step();
    rsp_ready_i = 1'b1;
    while (busy_o && waited < 60) begin
      step();
      waited++;
    end
    step();
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL fill_drain_timeout got busy=%b want 0", busy_o); end
    vectors++;
    if (log_cyc.size() != 5) begin miscompares++; $display("FAIL fill_strobe_count got %0d want 5", log_cyc.size()); end
    for (int j = 0; j < 5 && j < log_cyc.size(); j++) begin
      vectors++;
      if (log_addr[j] !== 12'h100 + 12'(j) || log_data[j] !== 32'hC0DE0000 + 32'(j)) begin
        miscompares++;
        $display("FAIL fill_order j=%0d got %h/%h want %h/%h", j, log_addr[j], log_data[j], 12'h100 + 12'(j), 32'hC0DE0000 + 32'(j));
      end
      if (j >= 2) begin
        vectors++;
        if (log_cyc[j] - log_cyc[j-1] != 5) begin
          miscompares++;
          $display("FAIL fill_spacing j=%0d got %0d want 5", j, log_cyc[j] - log_cyc[j-1]);
        end
      end
    end
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 19; k++) begin
      cmd_valid_i = (k <= 1);
      cmd_addr_i  = (k == 0) ? 12'h011 : 12'h022;
      cmd_data_i  = (k == 0) ? 32'h11111111 : 32'h22222222;
      xmpl_stone_status_i = 32'h50000000 + 32'(k);
      rsp_ready_i = (k == 15);
      vectors++;
      if (xmpl_stone_a_o !== (k == 2 || k == 17)) begin
        miscompares++;
        $display("FAIL bp_strobe k=%0d got %b want %b", k, xmpl_stone_a_o, (k == 2 || k == 17));
      end
      if (k >= 5 && k <= 15) begin
        vectors++;
        if (rsp_valid_o !== 1'b1 || rsp_status_o !== 32'h50000004) begin
          miscompares++;
          $display("FAIL bp_hold k=%0d got v=%b s=%h want v=1 s=50000004", k, rsp_valid_o, rsp_status_o);
        end
      end
      if (k == 17) begin
        vectors++;
        if (xmpl_stone_b_o !== 12'h022) begin miscompares++; $display("FAIL bp_second_b got %h want 022", xmpl_stone_b_o); end
      end
      step();
    end
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cmd_valid_i = (k == 0 || k == 1 || k == 6);
      cmd_addr_i  = (k == 0) ? 12'd1 : (k == 1) ? 12'd2 : 12'd3;
      cmd_data_i  = 32'hD0000000 | 32'(cmd_addr_i);
      xmpl_stone_status_i = 32'hA0000000 + 32'(k);
      rsp_ready_i = 1'b1;
      vectors++;
      if (xmpl_stone_a_o !== (k == 2 || k == 7 || k == 12)) begin
        miscompares++;
        $display("FAIL pp_strobe k=%0d got %b want %b", k, xmpl_stone_a_o, (k == 2 || k == 7 || k == 12));
      end
      if (k == 2 || k == 7 || k == 12) begin
        vectors++;
        if (xmpl_stone_b_o !== 12'(k / 5 + 1)) begin
          miscompares++;
          $display("FAIL pp_order k=%0d got %h want %h", k, xmpl_stone_b_o, 12'(k / 5 + 1));
        end
      end
      vectors++;
      if (rsp_valid_o !== (k == 5 || k == 10 || k == 15)) begin
        miscompares++;
        $display("FAIL pp_rsp_valid k=%0d got %b want %b", k, rsp_valid_o, (k == 5 || k == 10 || k == 15));
      end
      if (k == 5 || k == 10 || k == 15) begin
        vectors++;
        if (rsp_status_o !== 32'hA0000000 + 32'(k - 1)) begin
          miscompares++;
          $display("FAIL pp_status k=%0d got %h want %h", k, rsp_status_o, 32'hA0000000 + 32'(k - 1));
        end
      end
      if (k >= 16) begin
        vectors++;
        if (busy_o !== 1'b0) begin miscompares++; $display("FAIL pp_busy k=%0d got %b want 0", k, busy_o); end
      end
      step();
    end
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cmd_valid_i = (k <= 3);
      cmd_addr_i  = 12'h300 + 12'(k);
      cmd_data_i  = 32'(k);
      reset_i     = (k == 4);
      if (k == 2) begin
        vectors++;
        if (xmpl_stone_a_o !== 1'b1) begin miscompares++; $display("FAIL mid_first_strobe got %b want 1", xmpl_stone_a_o); end
      end
      step();
    end
    reset_i = 1'b0;
    cmd_valid_i = 1'b0;
    vectors++;
    if (xmpl_stone_a_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || rsp_status_o !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_after_reset got a=%b v=%b busy=%b rdy=%b s=%h want 0/0/0/1/0",
               xmpl_stone_a_o, rsp_valid_o, busy_o, cmd_ready_o, rsp_status_o);
    end
    for (int k = 0; k < 15; k++) begin
      vectors++;
      if (xmpl_stone_a_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_strobe k=%0d got a=%b v=%b want 0/0", k, xmpl_stone_a_o, rsp_valid_o);
      end
      step();
    end
  endtask

`ifdef XMPL_STONE_DRV_CNT_EN
  task automatic test_counter();
    int pushed = 0;
    int waited = 0;
    do_reset();
    vectors++;
    if (cmd_count_o !== 4'd0) begin miscompares++; $display("FAIL cnt_start got %0d want 0", cmd_count_o); end
    rsp_ready_i = 1'b1;
    while ((pushed < 17 || busy_o) && waited < 400) begin
      cmd_valid_i = (pushed < 17);
      cmd_addr_i  = 12'(pushed);
      if (cmd_valid_i && cmd_ready_o) pushed++;
      step();
      waited++;
    end
    cmd_valid_i = 1'b0;
    step();
    vectors++;
    if (busy_o !== 1'b0 || pushed != 17) begin miscompares++; $display("FAIL cnt_timeout got pushed=%0d busy=%b want 17/0", pushed, busy_o); end
    vectors++;
    if (cmd_count_o !== 4'd1) begin miscompares++; $display("FAIL cnt_wrap got %0d want 1", cmd_count_o); end
    do_reset();
    vectors++;
    if (cmd_count_o !== 4'd0) begin miscompares++; $display("FAIL cnt_reset got %0d want 0", cmd_count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_push_pop();
    test_reset_midop();
`ifdef XMPL_STONE_DRV_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
